alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001 Parameter NBYTES, default 4: operand width in bytes; wide operands are 8*NBYTES bits.
- REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-003 Port reset, input, 1: synchronous, active-high reset.
- REQ-004 Port req_valid, input, 1: request present.
- REQ-005 Port req_ready, output, 1: block can accept a request.
- REQ-006 Port req_op, input, 3: 0 AND, 1 OR, 2 NOT (uses a only), 3 ADD, 4 SUB, 5 EQ, 6-7 illegal.
- REQ-007 Ports req_a and req_b, input, 8*NBYTES each: wide operands.
- REQ-008 Port resp_valid, output, 1: response held until consumed.
- REQ-009 Port resp_ready, input, 1: consumer accepts the response.
- REQ-010 Port resp_res, output, 8*NBYTES: wide result.
- REQ-011 Port resp_carry, output, 1: ADD carry-out; SUB no-borrow (1 when a >= b unsigned).
- REQ-012 Port resp_eq, output, 1: EQ result; port resp_err, output, 1: illegal op.

Function
- REQ-013 The block SHALL sequence the shared 8-bit ALU, one ALU pass per clock, byte 0 (LSB) first, and latch each pass result at the end of its cycle.
- REQ-014 FSM states: IDLE, PASS_OP, PASS_CIN, NEXT_BYTE, DONE. req_ready=1 only in IDLE. Acceptance = req_valid && req_ready; operands and op are captured on that edge.
- REQ-015 AND/OR/NOT: one pass per byte using ALU AND/OR/NOT.
- REQ-016 ADD: pass A = a_i + b_i (ALU ADD), giving sum and c1. If carry-in is 1, pass B = sum + 1, giving c2. Byte carry-out = c1 | c2. Byte 0 carry-in = 0. Pass B is skipped when carry-in is 0.
- REQ-017 SUB: per byte, a NOT pass on b_i, then ADD per REQ-016 with a_i and ~b_i. Byte 0 carry-in = 1. resp_carry = final carry-out.
- REQ-018 EQ: one ALU BEQ pass per byte. resp_eq = AND of the per-byte jump outputs. resp_res = 0. The jump output SHALL be sampled only during EQ passes.
- REQ-019 Illegal op: zero passes. resp_err = 1; resp_res, resp_carry and resp_eq = 0.
- REQ-020 Latency: with P total passes, resp_valid SHALL rise P+1 cycles after the accepting edge.
- REQ-021 In DONE, resp_valid = 1 and all resp_* outputs SHALL be stable until resp_valid && resp_ready. The FSM then returns to IDLE; earliest next acceptance is the following cycle.
- REQ-022 resp_carry and resp_eq SHALL be 0 for ops they do not apply to.

Reset
- REQ-023 When reset=1 at an edge, the FSM SHALL enter IDLE and any in-flight operation SHALL be discarded with no response.
- REQ-024 Reset values: req_ready=1, resp_valid=0, resp_res=0, resp_carry=0, resp_eq=0, resp_err=0.
- REQ-025 Reset SHALL take priority over a simultaneous acceptance or response handshake.

Configuration
- REQ-026 Macro ALU_SEQ_EARLY_EXIT_EN defined: EQ SHALL go to DONE immediately after the first mismatching byte, with resp_eq=0.
- REQ-027 Macro ALU_SEQ_EARLY_EXIT_EN undefined: EQ SHALL always perform NBYTES passes.

Structure
- REQ-028 A shared package SHALL hold: the req_op encoding enum, the ALU opcode constants (AND 0, OR 2, NOT 3, ADD 4, BEQ 7), and the FSM state typedef.
- REQ-029 The block SHALL instantiate the 8-bit alu as its only sub-module. Byte index counter, carry register and result shift register are local.

Verification (NBYTES=4)
- REQ-030 ADD 0x00FFFFFF + 0x00000001 -> resp_res 0x01000000, carry 0, P=7, resp_valid 8 cycles after accept.
- REQ-031 SUB 0x00000005 - 0x00000006 -> resp_res 0xFFFFFFFF, carry 0. SUB 6 - 5 -> resp_res 0x00000001, carry 1.
- REQ-032 AND 0xF0F0F0F0 & 0xFF00FF00 -> resp_res 0xF000F000, resp_valid 5 cycles after accept.
- REQ-033 EQ 0x12345678 vs 0x12345679 -> resp_eq 0; latency 2 with ALU_SEQ_EARLY_EXIT_EN, 5 without. EQ of equal operands -> resp_eq 1, latency 5.
- REQ-034 resp_ready held 0 for 3 cycles in DONE -> resp_* stable, req_ready 0. Reset asserted mid-ADD -> next cycle req_ready 1, resp_valid 0, no response.
- REQ-035 req_op 7 -> resp_err 1, resp_res 0, resp_valid 1 cycle after accept.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the byte-serial ALU sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_NOT = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_EQ  = 3'd5
  } req_op_e;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_NOT = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd4;
  localparam logic [2:0] ALU_BEQ = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    PASS_OP,
    PASS_CIN,
    NEXT_BYTE,
    DONE
  } state_e;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// rtl/alu_seq_alu.sv - shared combinational 8-bit ALU (AND/OR/NOT/ADD/BEQ)
module alu_seq_alu
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] res,
  output logic       carry,
  output logic       jump
);

  always_comb begin
    res   = '0;
    carry = 1'b0;
    jump  = 1'b0;
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_NOT: res = ~a;
      ALU_ADD: {carry, res} = {1'b0, a} + {1'b0, b};
      ALU_BEQ: jump = (a == b);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - wide ALU built by sequencing one 8-bit ALU pass per clock, LSB first
// Option: define ALU_SEQ_EARLY_EXIT_EN to end EQ at the first mismatching byte.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [8*NBYTES-1:0] resp_res,
  output logic                resp_carry,
  output logic                resp_eq,
  output logic                resp_err
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES + 1);

  state_e        state, state_nxt;
  logic [2:0]    op_r;
  logic [W-1:0]  a_sr, b_sr, res_sr;
  logic [7:0]    tmp;
  logic          cin, inv_done, eq_acc;
  logic [IW-1:0] idx;

  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_carry, alu_jump;
  logic       add_like, last_byte, byte_done, carry_out, eq_miss;

  alu_seq_alu u_alu (
    .op    (alu_op),
    .a     (alu_a),
    .b     (alu_b),
    .res   (alu_res),
    .carry (alu_carry),
    .jump  (alu_jump)
  );

  assign add_like  = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign last_byte = (idx == IW'(NBYTES - 1));

  // SUB spends its first pass per byte inverting b into tmp; tmp then feeds the ADD pass.
  always_comb begin
    alu_op = ALU_AND;
    alu_a  = '0;
    alu_b  = '0;
    if (state == PASS_OP) begin
      case (op_r)
        OP_AND: begin alu_op = ALU_AND; alu_a = a_sr[7:0]; alu_b = b_sr[7:0]; end
        OP_OR:  begin alu_op = ALU_OR;  alu_a = a_sr[7:0]; alu_b = b_sr[7:0]; end
        OP_NOT: begin alu_op = ALU_NOT; alu_a = a_sr[7:0]; end
        OP_ADD: begin alu_op = ALU_ADD; alu_a = a_sr[7:0]; alu_b = b_sr[7:0]; end
        OP_SUB: begin
          if (!inv_done) begin alu_op = ALU_NOT; alu_a = b_sr[7:0]; end
          else begin alu_op = ALU_ADD; alu_a = a_sr[7:0]; alu_b = tmp; end
        end
        OP_EQ:  begin alu_op = ALU_BEQ; alu_a = a_sr[7:0]; alu_b = b_sr[7:0]; end
        default: ;
      endcase
    end else if (state == PASS_CIN) begin
      alu_op = ALU_ADD;
      alu_a  = tmp;
      alu_b  = 8'd1;
    end
  end

  always_comb begin
    byte_done = 1'b0;
    carry_out = alu_carry;
    if (state == PASS_CIN) begin
      byte_done = 1'b1;
      carry_out = cin | alu_carry;
    end else if (state == PASS_OP) begin
      byte_done = !((op_r == OP_SUB) && !inv_done) && !(add_like && cin);
    end
  end

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign eq_miss = (state == PASS_OP) && (op_r == OP_EQ) && !alu_jump;
`else
  assign eq_miss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = is_legal(req_op) ? PASS_OP : NEXT_BYTE;
      end
      PASS_OP: begin
        if (eq_miss || (byte_done && last_byte))   state_nxt = NEXT_BYTE;
        else if (byte_done)                        state_nxt = PASS_OP;
        else if ((op_r == OP_SUB) && !inv_done)    state_nxt = PASS_OP;
        else                                       state_nxt = PASS_CIN;
      end
      PASS_CIN:  state_nxt = last_byte ? NEXT_BYTE : PASS_OP;
      NEXT_BYTE: state_nxt = DONE;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NEXT_BYTE is the single commit cycle after the last pass; resp_* only change there.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r       <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      tmp        <= '0;
      cin        <= 1'b0;
      inv_done   <= 1'b0;
      eq_acc     <= 1'b0;
      idx        <= '0;
      resp_res   <= '0;
      resp_carry <= 1'b0;
      resp_eq    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_r     <= req_op;
            a_sr     <= req_a;
            b_sr     <= req_b;
            idx      <= '0;
            inv_done <= 1'b0;
            eq_acc   <= 1'b1;
            cin      <= (req_op == OP_SUB);
          end
        end
        PASS_OP, PASS_CIN: begin
          if ((state == PASS_OP) && (op_r == OP_EQ)) eq_acc <= eq_acc & alu_jump;
          if (byte_done) begin
            res_sr   <= (res_sr >> 8) | (W'(alu_res) << (W - 8));
            a_sr     <= a_sr >> 8;
            b_sr     <= b_sr >> 8;
            idx      <= idx + 1'b1;
            inv_done <= 1'b0;
            cin      <= carry_out;
          end else if ((op_r == OP_SUB) && !inv_done) begin
            tmp      <= alu_res;
            inv_done <= 1'b1;
          end else begin
            tmp <= alu_res;
            cin <= alu_carry;
          end
        end
        NEXT_BYTE: begin
          resp_err   <= !is_legal(op_r);
          resp_res   <= (is_legal(op_r) && (op_r != OP_EQ)) ? res_sr : '0;
          resp_carry <= add_like & cin;
          resp_eq    <= (op_r == OP_EQ) & eq_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (NBYTES=4), honours ALU_SEQ_EARLY_EXIT_EN
module tb_alu_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         resp_ready = 1'b0;
  logic [2:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_ready, resp_valid, resp_carry, resp_eq, resp_err;
  logic [W-1:0] resp_res;

  alu_seq #(.NBYTES(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_res   (resp_res),
    .resp_carry (resp_carry),
    .resp_eq    (resp_eq),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    logic         eq;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic q,
                              input logic er, input int l);
    exp_t e;
    e.res = r; e.carry = c; e.eq = q; e.err = er; e.lat = l;
    return e;
  endfunction

  // Reference: values from whole-word arithmetic, pass count from the per-byte carry chain.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int p;
    logic c;
    logic [8:0] s;
    logic [W:0] wide;
    e = mk('0, 1'b0, 1'b0, 1'b0, 0);
    p = NB;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = ~a;
      3'd3: begin
        wide = {1'b0, a} + {1'b0, b};
        e.res = wide[W-1:0];
        e.carry = wide[W];
        c = 1'b0; p = 0;
        for (int i = 0; i < NB; i++) begin
          p += 1 + int'(c);
          s = {1'b0, a[8*i+:8]} + {1'b0, b[8*i+:8]} + 9'(c);
          c = s[8];
        end
      end
      3'd4: begin
        e.res = a - b;
        e.carry = (a >= b);
        c = 1'b1; p = 0;
        for (int i = 0; i < NB; i++) begin
          p += 2 + int'(c);
          s = {1'b0, a[8*i+:8]} + {1'b0, ~b[8*i+:8]} + 9'(c);
          c = s[8];
        end
      end
      3'd5: begin
        e.eq = (a == b);
`ifdef ALU_SEQ_EARLY_EXIT_EN
        for (int i = NB - 1; i >= 0; i--) if (a[8*i+:8] != b[8*i+:8]) p = i + 1;
`endif
      end
      default: begin e.err = 1'b1; p = 0; end
    endcase
    e.lat = p + 1;
    return e;
  endfunction

  task automatic run_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input int hold);
    exp_t x;
    int lat;
    int w;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; resp_ready = 1'b0;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    check("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    x = sb.pop_front();
    check("latency", 64'(lat), 64'(x.lat));
    check("resp_res", 64'(resp_res), 64'(x.res));
    check("resp_carry", {63'd0, resp_carry}, {63'd0, x.carry});
    check("resp_eq", {63'd0, resp_eq}, {63'd0, x.eq});
    check("resp_err", {63'd0, resp_err}, {63'd0, x.err});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      check("hold_res", 64'(resp_res), 64'(x.res));
      check("hold_flags", {61'd0, resp_carry, resp_eq, resp_err}, {61'd0, x.carry, x.eq, x.err});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("released_valid", {63'd0, resp_valid}, 64'd0);
    check("released_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int eq_lat_miss;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_res", 64'(resp_res), 64'd0);
    check("rst_flags", {61'd0, resp_carry, resp_eq, resp_err}, 64'd0);
    reset = 1'b0;

`ifdef ALU_SEQ_EARLY_EXIT_EN
    eq_lat_miss = 2;
`else
    eq_lat_miss = 5;
`endif

    run_req(3'd3, 32'h00FF_FFFF, 32'h0000_0001, mk(32'h0100_0000, 1'b0, 1'b0, 1'b0, 8), 0);
    run_req(3'd4, 32'h0000_0005, 32'h0000_0006, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 10), 0);
    run_req(3'd4, 32'h0000_0006, 32'h0000_0005, mk(32'h0000_0001, 1'b1, 1'b0, 1'b0, 13), 1);
    run_req(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 1'b0, 1'b0, 1'b0, 5), 3);
    run_req(3'd5, 32'h1234_5678, 32'h1234_5679, mk(32'h0, 1'b0, 1'b0, 1'b0, eq_lat_miss), 0);
    run_req(3'd5, 32'h1234_5678, 32'h1234_5678, mk(32'h0, 1'b0, 1'b1, 1'b0, 5), 0);
    run_req(3'd7, 32'hDEAD_BEEF, 32'h1111_1111, mk(32'h0, 1'b0, 1'b0, 1'b1, 1), 2);
    run_req(3'd6, 32'h1, 32'h1, mk(32'h0, 1'b0, 1'b0, 1'b1, 1), 0);
    run_req(3'd3, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0, 1'b1, 1'b0, 1'b0, 8), 0);
    run_req(3'd2, 32'h0F0F_00FF, 32'h0, mk(32'hF0F0_FF00, 1'b0, 1'b0, 1'b0, 5), 0);

    // Reset in the middle of an ADD must discard it silently.
    @(negedge clk);
    req_op = 3'd3; req_a = 32'h00FF_FFFF; req_b = 32'h1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midop_busy", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midop_rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("midop_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("no_resp_after_reset", {63'd0, resp_valid}, 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (op == 3'd5 && n[0]) b = a;
      if (op == 3'd5 && n[1]) b = a ^ (32'h1 << $urandom_range(0, 31));
      run_req(op, a, b, model(op, a, b), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
